bus_arbiter: RTL

- Shares the single simple bus (bus_en/wr_en/addr/wr_data/byte_en, ack/rd_data) between N requesters, e.g. core bus adapter plus a DMA or debug master.
- Uses round-robin arbitration with one outstanding transaction at a time.
- Each grant is held until slave ack or timeout.
- Sits between the per-master bus adapters and the memory/peripheral interconnect.

---
 rtl/bus_arbiter_pkg.sv | 14 +
 rtl/bus_arbiter_rr_picker.sv | 30 +++
 rtl/bus_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared constants and state encoding for the round-robin bus arbiter.
// Also imported by other blocks that drive the simple slave bus.
package bus_arbiter_pkg;

    localparam int XLEN    = 32;
    localparam int BUS_AW  = 32;
    localparam int BUS_BEW = 4;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin picker: the first set request after index 'last' wins.
// Kept generic so interrupt and CSR arbitration can reuse it.
module rr_picker #(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          valid
);

    always_comb begin
        // NOTE: every output gets a default before the loop, so no path leaves one unassigned and no latch is inferred.
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        for (int i = 1; i <= N; i++) begin
            int k;
            k = (int'(last) + i) % N;
            if (!valid && req[k]) begin
                valid    = 1'b1;
                idx      = k[IW-1:0];
                grant[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one simple slave bus between N masters.
// One transaction at a time; each grant ends on slave ack or watchdog timeout.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int TIMEOUT   = 0,
    parameter int TO_W      = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [N_MASTERS-1:0]         i_m_req,
    input  logic [N_MASTERS-1:0]         i_m_wr_en,
    input  logic [BUS_AW*N_MASTERS-1:0]  i_m_addr,
    input  logic [XLEN*N_MASTERS-1:0]    i_m_wr_data,
    input  logic [BUS_BEW*N_MASTERS-1:0] i_m_byte_en,
    output logic [N_MASTERS-1:0]         o_m_ack,
    output logic [N_MASTERS-1:0]         o_m_err,
    output logic [XLEN-1:0]              o_m_rd_data,
    output logic [N_MASTERS-1:0]         o_grant,
    output logic                         o_bus_en,
    output logic                         o_wr_en,
    output logic [BUS_AW-1:0]            o_addr,
    output logic [XLEN-1:0]              o_wr_data,
    output logic [BUS_BEW-1:0]           o_byte_en,
    input  logic                         i_ack,
    input  logic [XLEN-1:0]              i_rd_data
);

    localparam int IW = $clog2(N_MASTERS);
    localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

    arb_state_t           state, state_d;
    logic [IW-1:0]        last, last_d;
    logic [TO_W-1:0]      cnt, cnt_d;
    logic [N_MASTERS-1:0] grant_d;
    logic                 bus_en_d, wr_en_d;
    logic [BUS_AW-1:0]    addr_d;
    logic [XLEN-1:0]      wr_data_d;
    logic [BUS_BEW-1:0]   byte_en_d;

    logic [N_MASTERS-1:0] pick_grant;
    logic [IW-1:0]        pick_idx;
    logic                 pick_valid;
    logic                 ack_ev, to_ev;

    rr_picker #(.N(N_MASTERS)) u_picker (
        .req   (i_m_req),
        .last  (last),
        .grant (pick_grant),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // An ack in the watchdog's final cycle suppresses the timeout, so ack wins ties.
    assign ack_ev = (state == ARB_BUSY) && i_ack;
    assign to_ev  = (TIMEOUT != 0) && (state == ARB_BUSY) && !i_ack && (cnt == TO_LAST);

    assign o_m_ack     = (ack_ev || to_ev) ? o_grant : '0;
    assign o_m_err     = to_ev ? o_grant : '0;
    assign o_m_rd_data = ack_ev ? i_rd_data : '0;

    always_comb begin
        state_d   = state;
        last_d    = last;
        cnt_d     = cnt;
        grant_d   = o_grant;
        bus_en_d  = o_bus_en;
        wr_en_d   = o_wr_en;
        addr_d    = o_addr;
        wr_data_d = o_wr_data;
        byte_en_d = o_byte_en;
        case (state)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_d   = ARB_BUSY;
                    bus_en_d  = 1'b1;
                    wr_en_d   = i_m_wr_en[pick_idx];
                    addr_d    = i_m_addr[int'(pick_idx) * BUS_AW +: BUS_AW];
                    wr_data_d = i_m_wr_data[int'(pick_idx) * XLEN +: XLEN];
                    byte_en_d = i_m_byte_en[int'(pick_idx) * BUS_BEW +: BUS_BEW];
                    grant_d   = pick_grant;
                    last_d    = pick_idx;
                    cnt_d     = '0;
                end
            end
            ARB_BUSY: begin
                if (ack_ev || to_ev) begin
                    state_d   = ARB_IDLE;
                    bus_en_d  = 1'b0;
                    wr_en_d   = 1'b0;
                    addr_d    = '0;
                    wr_data_d = '0;
                    byte_en_d = '0;
                    grant_d   = '0;
                end else if (cnt != '1) begin
                    cnt_d = cnt + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state     <= ARB_IDLE;
            last      <= IW'(N_MASTERS - 1);
            cnt       <= '0;
            o_grant   <= '0;
            o_bus_en  <= 1'b0;
            o_wr_en   <= 1'b0;
            o_addr    <= '0;
            o_wr_data <= '0;
            o_byte_en <= '0;
        end else begin
            // NOTE: non-blocking assignments make every register update from pre-edge values.
            state     <= state_d;
            last      <= last_d;
            cnt       <= cnt_d;
            o_grant   <= grant_d;
            o_bus_en  <= bus_en_d;
            o_wr_en   <= wr_en_d;
            o_addr    <= addr_d;
            o_wr_data <= wr_data_d;
            o_byte_en <= byte_en_d;
        end
    end

endmodule
